// File: rtl/pla_pkg.sv
// Shared constants for the piecewise-linear activation unit: cfg table select codes,
// softplus reset defaults and the output saturation helper.
package pla_pkg;

    localparam logic [1:0] CFG_SLOPE = 2'd0;
    localparam logic [1:0] CFG_ICPT  = 2'd1;
    localparam logic [1:0] CFG_BP    = 2'd2;
    localparam logic [1:0] CFG_FLOOR = 2'd3;

    localparam int DEF_SLOPE [4] = '{4, 55, 201, 252};
    localparam int DEF_ICPT  [4] = '{24, 177, 177, 24};
    localparam int DEF_BP    [5] = '{-1536, -768, 0, 768, 1536};
    localparam int DEF_FLOOR     = 0;

    // Widest supported sample width; the saturate helper works at this size.
    localparam int PLA_MAXW = 32;

    function automatic int def_slope(input int k);
        case (k)
            0:       return DEF_SLOPE[0];
            1:       return DEF_SLOPE[1];
            2:       return DEF_SLOPE[2];
            3:       return DEF_SLOPE[3];
            default: return 0;
        endcase
    endfunction

    function automatic int def_icpt(input int k);
        case (k)
            0:       return DEF_ICPT[0];
            1:       return DEF_ICPT[1];
            2:       return DEF_ICPT[2];
            3:       return DEF_ICPT[3];
            default: return 0;
        endcase
    endfunction

    function automatic int def_bp(input int k);
        case (k)
            0:       return DEF_BP[0];
            1:       return DEF_BP[1];
            2:       return DEF_BP[2];
            3:       return DEF_BP[3];
            4:       return DEF_BP[4];
            default: return 0;
        endcase
    endfunction

    // Clamp a (2*w+1)-bit result, sign-extended to 2*PLA_MAXW+1 bits, into w bits.
    function automatic logic signed [PLA_MAXW-1:0] saturate(
        input logic signed [2*PLA_MAXW:0] r,
        input int unsigned                w
    );
        logic signed [2*PLA_MAXW:0] hi;
        logic signed [2*PLA_MAXW:0] lo;
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (r > hi)
            return hi[PLA_MAXW-1:0];
        else if (r < lo)
            return lo[PLA_MAXW-1:0];
        else
            return r[PLA_MAXW-1:0];
    endfunction

endpackage

// File: rtl/pla_act_unit_seg_select.sv
// Comparator bank: counts breakpoints strictly below x and maps the count to a
// segment index, or flags the floor region when no breakpoint is below x.
module pla_seg_select #(
    parameter int WIDTH  = 16,
    parameter int SLICES = 4,
    parameter int IW     = $clog2(SLICES)
) (
    input  logic signed [WIDTH-1:0]          x,
    input  logic        [(SLICES+1)*WIDTH-1:0] bp,
    output logic        [IW-1:0]             idx,
    output logic                             floor_hit
);

    int n;

    always_comb begin
        n = 0;
        for (int k = 0; k <= SLICES; k++) begin
            if ($signed(bp[k*WIDTH +: WIDTH]) < x)
                n = n + 1;
        end
        floor_hit = (n == 0);
        if (n == 0)
            idx = '0;
        else if (n - 1 > SLICES - 1)
            idx = IW'(SLICES - 1);
        else
            idx = IW'(n - 1);
    end

endmodule

// File: rtl/pla_act_unit.sv
// Piecewise-linear activation unit: 3-stage valid/ready pipeline with a writable
// coefficient table. Optional PLA_ROUND_EN selects round-half-up instead of truncation.
module pla_act_unit
    import pla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FP     = 8,
    parameter int SLICES = 4,
    parameter int AW     = $clog2(SLICES+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    input  logic                    cfg_we,
    input  logic [1:0]              cfg_sel,
    input  logic [AW-1:0]           cfg_addr,
    input  logic signed [WIDTH-1:0] cfg_wdata
);

    localparam int IW = $clog2(SLICES);

    logic signed [WIDTH-1:0] slope_q [SLICES];
    logic signed [WIDTH-1:0] icpt_q  [SLICES];
    logic signed [WIDTH-1:0] bp_q    [SLICES+1];
    logic signed [WIDTH-1:0] floor_q;
    logic [(SLICES+1)*WIDTH-1:0] bp_flat;

    logic                    en;
    logic [IW-1:0]           seg_idx;
    logic                    seg_floor;
    logic signed [WIDTH-1:0] slope_s, icpt_s;

    logic                    v1, v2;
    logic signed [WIDTH-1:0] x1, slope1, icpt1, flv1, icpt2, flv2;
    logic                    flr1, flr2;
    logic signed [2*WIDTH-1:0] p2;

    logic signed [2*WIDTH:0]    pe, q3, r3;
    logic signed [2*PLA_MAXW:0] r_ext;
    logic signed [PLA_MAXW-1:0] sat_full;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Table writes land regardless of pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SLICES; k++) begin
                slope_q[k] <= WIDTH'(def_slope(k));
                icpt_q[k]  <= WIDTH'(def_icpt(k));
            end
            for (int k = 0; k <= SLICES; k++)
                bp_q[k] <= WIDTH'(def_bp(k));
            floor_q <= WIDTH'(DEF_FLOOR);
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_SLOPE:
                    for (int k = 0; k < SLICES; k++)
                        if (cfg_addr == AW'(k)) slope_q[k] <= cfg_wdata;
                CFG_ICPT:
                    for (int k = 0; k < SLICES; k++)
                        if (cfg_addr == AW'(k)) icpt_q[k] <= cfg_wdata;
                CFG_BP:
                    for (int k = 0; k <= SLICES; k++)
                        if (cfg_addr == AW'(k)) bp_q[k] <= cfg_wdata;
                default:
                    if (int'(cfg_addr) < SLICES) floor_q <= cfg_wdata;
            endcase
        end
    end

    always_comb begin
        bp_flat = '0;
        for (int k = 0; k <= SLICES; k++)
            bp_flat[k*WIDTH +: WIDTH] = bp_q[k];
    end

    pla_seg_select #(
        .WIDTH  (WIDTH),
        .SLICES (SLICES),
        .IW     (IW)
    ) u_seg (
        .x         (in_data),
        .bp        (bp_flat),
        .idx       (seg_idx),
        .floor_hit (seg_floor)
    );

    always_comb begin
        slope_s = '0;
        icpt_s  = '0;
        for (int k = 0; k < SLICES; k++) begin
            if (seg_idx == IW'(k)) begin
                slope_s = slope_q[k];
                icpt_s  = icpt_q[k];
            end
        end
    end

    // Shift, optional rounding bias, intercept add, all at 2*WIDTH+1 bits.
    always_comb begin
        pe = {p2[2*WIDTH-1], p2};
`ifdef PLA_ROUND_EN
        pe = pe + (2*WIDTH+1)'(2**(FP-1));
`endif
        q3       = pe >>> FP;
        r3       = q3 + {{(WIDTH+1){icpt2[WIDTH-1]}}, icpt2};
        r_ext    = r3;
        sat_full = saturate(r_ext, WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            x1        <= '0;
            slope1    <= '0;
            icpt1     <= '0;
            flr1      <= 1'b0;
            flv1      <= '0;
            p2        <= '0;
            icpt2     <= '0;
            flr2      <= 1'b0;
            flv2      <= '0;
        end else if (en) begin
            v1 <= in_valid;
            if (in_valid) begin
                x1     <= in_data;
                slope1 <= slope_s;
                icpt1  <= icpt_s;
                flr1   <= seg_floor;
                flv1   <= floor_q;
            end
            v2 <= v1;
            if (v1) begin
                p2    <= x1 * slope1;
                icpt2 <= icpt1;
                flr2  <= flr1;
                flv2  <= flv1;
            end
            out_valid <= v2;
            if (v2)
                out_data <= flr2 ? flv2 : sat_full[WIDTH-1:0];
        end
    end

endmodule
